// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
package mem_arb_pkg;

  // Arbiter FSM state, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  // Which port was granted most recently.
  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between an
// instruction-fetch read port and a data read/write port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        if_stall,
  output logic        d_stall
);

  localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

  arb_state_t  state;
  grant_t      last_grant;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        active;

  // FSM: grant in IDLE, count out the memory latency, capture read data and
  // pulse ready, then spend one RESP cycle so a held request is not re-issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GNT_INST;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            cnt <= '0;
            if (d_req && (!if_req || last_grant == GNT_INST)) begin
              state      <= DATA;
              addr_q     <= d_addr;
              we_q       <= d_we;
              wdata_q    <= d_wdata;
              last_grant <= GNT_DATA;
            end else begin
              state      <= INST;
              addr_q     <= if_addr;
              we_q       <= 1'b0;
              wdata_q    <= '0;
              last_grant <= GNT_INST;
            end
          end
        end
        INST, DATA: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST_CNT) begin
            state <= RESP;
            if (state == INST) begin
              if_rdata <= mem_rdata;
              if_ready <= 1'b1;
            end else begin
              if (!we_q) d_rdata <= mem_rdata;
              d_ready <= 1'b1;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side outputs decode straight from registered state, so they are
  // zero in IDLE/RESP and drop immediately when rst forces IDLE.
  always_comb begin
    active    = (state == INST) || (state == DATA);
    mem_en    = active;
    mem_addr  = active ? addr_q  : '0;
    mem_wdata = active ? wdata_q : '0;
    mem_we    = (state == DATA) && we_q && (cnt == LAST_CNT);
  end

  // Requester stall indications.
  always_comb begin
    if_stall = if_req & ~if_ready;
    d_stall  = d_req  & ~d_ready;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with MEM_LATENCY=2.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        if_stall;
  logic        d_stall;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.MEM_LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .if_stall(if_stall), .d_stall(d_stall)
  );

  always #5 clk = ~clk;

  // Big-endian byte memory, combinational read.
  logic [7:0]  mem [0:4095];
  logic        pl_we = 1'b0;
  logic [11:0] pl_a = '0;
  logic [31:0] pl_d = '0;
  logic [11:0] ra;
  assign ra = mem_addr[11:0];
  assign mem_rdata = {mem[ra], mem[ra + 12'd1], mem[ra + 12'd2], mem[ra + 12'd3]};

  always @(posedge clk) begin
    if (pl_we) begin
      mem[pl_a] <= pl_d[31:24]; mem[pl_a + 12'd1] <= pl_d[23:16];
      mem[pl_a + 12'd2] <= pl_d[15:8]; mem[pl_a + 12'd3] <= pl_d[7:0];
    end else if (mem_en && mem_we) begin
      mem[ra] <= mem_wdata[31:24]; mem[ra + 12'd1] <= mem_wdata[23:16];
      mem[ra + 12'd2] <= mem_wdata[15:8]; mem[ra + 12'd3] <= mem_wdata[7:0];
    end
  end

  // Per-negedge trace: bit i is the value seen at the negedge after edge Ei.
  logic [31:0] en_v, we_v, ir_v, dr_v;
  logic [31:0] addr_t [32];

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk); pl_we = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk); pl_we = 1'b0;
  endtask

  task automatic capture(input int n);
    en_v = '0; we_v = '0; ir_v = '0; dr_v = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en_v[i] = mem_en; we_v[i] = mem_we; ir_v[i] = if_ready; dr_v[i] = d_ready;
      addr_t[i] = mem_addr;
    end
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); clear_inputs(); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({if_ready, d_ready, mem_en, mem_we, if_stall, d_stall} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 000000",
                        {if_ready, d_ready, mem_en, mem_we, if_stall, d_stall});
    end
    n_cmp++;
    if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== 128'b0) begin
      n_err++; $display("FAIL reset_data: if_rdata=%h d_rdata=%h mem_addr=%h want 0",
                        if_rdata, d_rdata, mem_addr);
    end
    rst = 1'b0;
    capture(3);
    n_cmp++;
    if (en_v !== 32'h0) begin
      n_err++; $display("FAIL reset_idle: en trace %h want 0", en_v);
    end
  endtask

  task automatic test_lone_fetch();
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    n_cmp++;
    if (if_stall !== 1'b1) begin
      n_err++; $display("FAIL fetch_stall: got %b want 1", if_stall);
    end
    capture(3);
    n_cmp++;
    if (en_v !== 32'h3 || addr_t[0] !== 32'h10 || addr_t[1] !== 32'h10) begin
      n_err++; $display("FAIL fetch_en: en=%h addr0=%h want en=3 addr=10", en_v, addr_t[0]);
    end
    n_cmp++;
    if (ir_v !== 32'h4 || dr_v !== 32'h0) begin
      n_err++; $display("FAIL fetch_ready: ir=%h dr=%h want ir=4 dr=0", ir_v, dr_v);
    end
    n_cmp++;
    if (if_rdata !== 32'h8C020000) begin
      n_err++; $display("FAIL fetch_rdata: got %h want 8c020000", if_rdata);
    end
    n_cmp++;
    if (if_stall !== 1'b0) begin
      n_err++; $display("FAIL fetch_stall_done: got %b want 0", if_stall);
    end
    clear_inputs();
    capture(4);
    n_cmp++;
    if (en_v !== 32'h0 || ir_v !== 32'h0) begin
      n_err++; $display("FAIL fetch_once: en=%h ir=%h want 0", en_v, ir_v);
    end
  endtask

  task automatic test_tie();
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3E8;
    capture(8);
    clear_inputs();
    n_cmp++;
    if (addr_t[0] !== 32'h3E8 || addr_t[4] !== 32'h10) begin
      n_err++; $display("FAIL tie_order: first=%h second=%h want 3e8 then 10", addr_t[0], addr_t[4]);
    end
    n_cmp++;
    if (dr_v !== 32'h4 || ir_v !== 32'h40) begin
      n_err++; $display("FAIL tie_ready: dr=%h ir=%h want dr=4 ir=40", dr_v, ir_v);
    end
    n_cmp++;
    if (en_v !== 32'h33) begin
      n_err++; $display("FAIL tie_en: got %h want 33", en_v);
    end
    n_cmp++;
    if (d_rdata !== 32'h0000006E || if_rdata !== 32'h8C020000) begin
      n_err++; $display("FAIL tie_rdata: d=%h i=%h want 0000006e 8c020000", d_rdata, if_rdata);
    end
  endtask

  task automatic test_store();
    preload(12'h3E8, 32'hFFFFFFFF);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3E8; d_wdata = 32'h0000006E;
    capture(3);
    clear_inputs();
    n_cmp++;
    if (we_v !== 32'h2 || en_v !== 32'h3) begin
      n_err++; $display("FAIL store_we: we=%h en=%h want we=2 en=3", we_v, en_v);
    end
    n_cmp++;
    if (dr_v !== 32'h4 || ir_v !== 32'h0) begin
      n_err++; $display("FAIL store_ready: dr=%h ir=%h want dr=4 ir=0", dr_v, ir_v);
    end
    n_cmp++;
    if ({mem[12'h3E8], mem[12'h3E9], mem[12'h3EA], mem[12'h3EB]} !== 32'h0000006E) begin
      n_err++; $display("FAIL store_mem: got %h want 0000006e",
                        {mem[12'h3E8], mem[12'h3E9], mem[12'h3EA], mem[12'h3EB]});
    end
    n_cmp++;
    if (d_rdata !== 32'h0000006E) begin
      n_err++; $display("FAIL store_rdata_kept: got %h want 0000006e", d_rdata);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3E8;
    capture(20);
    clear_inputs();
    n_cmp++;
    if (dr_v !== 32'h00040404 || ir_v !== 32'h00004040) begin
      n_err++; $display("FAIL contend_ready: dr=%h ir=%h want 00040404 00004040", dr_v, ir_v);
    end
    n_cmp++;
    if (en_v !== 32'h00033333) begin
      n_err++; $display("FAIL contend_en: got %h want 00033333", en_v);
    end
    n_cmp++;
    if (addr_t[0] !== 32'h3E8 || addr_t[4] !== 32'h10 || addr_t[8] !== 32'h3E8 ||
        addr_t[12] !== 32'h10 || addr_t[16] !== 32'h3E8) begin
      n_err++; $display("FAIL contend_order: %h %h %h %h %h want D,I,D,I,D",
                        addr_t[0], addr_t[4], addr_t[8], addr_t[12], addr_t[16]);
    end
  endtask

  task automatic test_abort();
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    capture(2);
    n_cmp++;
    if (en_v !== 32'h3 || ir_v !== 32'h0) begin
      n_err++; $display("FAIL abort_pre: en=%h ir=%h want en=3 ir=0", en_v, ir_v);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({mem_en, mem_we, if_ready, d_ready} !== 4'b0 || mem_addr !== 32'h0 ||
        if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      n_err++; $display("FAIL abort_async: en=%b we=%b ir=%b dr=%b addr=%h ird=%h drd=%h want 0",
                        mem_en, mem_we, if_ready, d_ready, mem_addr, if_rdata, d_rdata);
    end
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    capture(4);
    n_cmp++;
    if (ir_v !== 32'h0 || dr_v !== 32'h0 || we_v !== 32'h0 || en_v !== 32'h0) begin
      n_err++; $display("FAIL abort_quiet: ir=%h dr=%h we=%h en=%h want 0", ir_v, dr_v, we_v, en_v);
    end
    n_cmp++;
    if (if_rdata !== 32'h0) begin
      n_err++; $display("FAIL abort_rdata: got %h want 0", if_rdata);
    end
    if_req = 1'b1; if_addr = 32'h10;
    capture(3);
    clear_inputs();
    n_cmp++;
    if (ir_v !== 32'h4 || if_rdata !== 32'h8C020000) begin
      n_err++; $display("FAIL abort_refetch: ir=%h rdata=%h want 4 8c020000", ir_v, if_rdata);
    end
  endtask

  initial begin
    test_reset();
    preload(12'h010, 32'h8C020000);
    preload(12'h3E8, 32'h0000006E);
    test_lone_fetch();
    test_tie();
    test_store();
    preload(12'h3E8, 32'h0000006E);
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 2, giving the cycles the shared memory needs per access (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, clock.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have ports if_req (in, 1), if_addr (in, 32), if_rdata (out, 32), if_ready (out, 1), the instruction-fetch read port.
REQ-005 SHALL have ports d_req (in, 1), d_we (in, 1), d_addr (in, 32), d_wdata (in, 32), d_rdata (out, 32), d_ready (out, 1), the data read/write port.
REQ-006 SHALL have ports mem_en (out, 1), mem_we (out, 1), mem_addr (out, 32), mem_wdata (out, 32), mem_rdata (in, 32), the single-ported byte-addressed big-endian memory with combinational read.
REQ-007 SHALL have ports if_stall (out, 1) = if_req & ~if_ready and d_stall (out, 1) = d_req & ~d_ready, both combinational.

Function
REQ-008 SHALL implement FSM states IDLE, INST, DATA and RESP.
REQ-009 SHALL accept a request only in IDLE; requests in other states are ignored until IDLE.
REQ-010 In IDLE with one request, SHALL grant that port; with both, SHALL grant the port opposite to last_grant (round robin).
REQ-011 On grant, SHALL latch the address, plus we and wdata for the data port; go to INST or DATA; clear cnt to 0; and update last_grant.
REQ-012 In INST/DATA, SHALL drive mem_en=1 and mem_addr/mem_wdata from the latched values; cnt increments each cycle.
REQ-013 SHALL assert mem_we only in DATA with latched we=1 and cnt==MEM_LATENCY-1, giving exactly one write edge per store.
REQ-014 At the edge where cnt==MEM_LATENCY-1, SHALL register mem_rdata into if_rdata (INST) or into d_rdata (DATA read only), pulse the matching ready for one cycle, and go to RESP.
REQ-015 SHALL leave d_rdata unchanged on writes; each rdata holds its value until that port's next read completes.
REQ-016 RESP SHALL last one cycle with mem_en=0, then go to IDLE, so a held req is not re-issued.
REQ-017 Latency: a request sampled at edge E0 SHALL give ready high in the cycle after edge E(MEM_LATENCY); minimum spacing between grants is MEM_LATENCY+2 cycles.
REQ-018 Requesters SHALL hold req/addr/wdata stable until ready; the arbiter does not check alignment and passes addr[1:0] through unchanged.
REQ-019 The outputs mem_en, mem_we, mem_addr and mem_wdata SHALL be 0 in IDLE and RESP.

Reset
REQ-020 rst SHALL force IDLE immediately, including mid-access, with cnt=0 and last_grant=INST so that data wins the first tie.
REQ-021 While rst is high, SHALL drive if_ready, d_ready, mem_en and mem_we to 0 and if_rdata, d_rdata and mem_addr to 0.
REQ-022 An access aborted by rst SHALL produce no ready pulse and no mem_we.

Structure
REQ-023 State encoding (2-bit) and grant encoding (INST=0, DATA=1) SHALL live in shared package mem_arb_pkg.
REQ-024 SHALL be a single module with no sub-modules; the latency counter is an inline 4-bit register.

Verification (MEM_LATENCY=2)
REQ-025 Reset: assert rst mid-run -> all outputs are 0 in the same cycle; after release the block is in IDLE.
REQ-026 Lone fetch: if_req=1, if_addr=0x10, memory word 0x8C020000 -> mem_en high 2 cycles, if_ready pulses once with if_rdata=0x8C020000, next grant no earlier than 4 cycles after the first.
REQ-027 Tie after reset: if_req=d_req=1, d_addr=0x3E8 read (word 0x6E) -> DATA granted first with d_rdata=0x0000006E, then INST; if_ready follows d_ready by 4 cycles.
REQ-028 Store: d_we=1, d_addr=0x3E8, d_wdata=0x0000006E -> mem_we high exactly 1 cycle; memory 0x3E8..0x3EB = 00 00 00 6E; d_ready pulses; d_rdata unchanged.
REQ-029 Sustained contention with both req held 20 cycles -> grants alternate D,I,D,I,D; each ready is one cycle wide.
REQ-030 Abort: rst asserted while INST and cnt=1 -> no if_ready pulse, if_rdata=0, and a fresh if_req after release completes normally.
